arb_mux_n: RTL and testbench
============================

# arb_mux_n

Parametrised N-channel arbitrating multiplexer with valid/ready handshakes and a one-entry registered output. It merges N producer streams into one consumer stream. Arbitration is selectable at run time between fixed priority (highest index wins) and round-robin. The block sits between request sources and a shared datapath resource, and the granted channel index travels with each data word.

## Interface
- `N`, default 4: number of input channels, ≥2.
- `W`, default 8: data width per channel.
- `IW`, default `$clog2(N)`: channel index width; derived, never overridden.

- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `mode`, input, 1: 0 selects fixed priority; 1 selects round-robin.
- `in_valid`, input, N: per-channel request; bit i belongs to channel i.
- `in_data`, input, N*W: channel i occupies bits [i*W +: W].
- `in_ready`, output, N: per-channel accept; at most one bit is set per cycle.
- `out_valid`, output, 1: the output register holds a word.
- `out_data`, output, W: the registered word.
- `out_ch`, output, IW: index of the channel that supplied `out_data`.
- `out_ready`, input, 1: consumer accepts the word when both `out_valid` and `out_ready` are 1.

## Operation
- Load enable: `ld = !out_valid || out_ready`.
- Winner selection is combinational over `in_valid`:
  - Fixed priority (`mode=0`): the highest-index asserted channel wins, so 4'b0110 selects channel 2.
  - Round-robin (`mode=1`): search starts at `(ptr+1) mod N`, ascending with wrap, and the first asserted channel wins. `ptr` is the last granted index.
- `in_ready[k]=1` only when `ld=1` and k is the winner. All other bits are 0. With no request, `in_ready` is all 0.
- On a clock edge with `ld=1`:
  - If any request is asserted: `out_data` takes the winner's data, `out_ch` takes the winner's index, `out_valid` goes to 1, and `ptr` takes the winner's index. `ptr` updates in both modes.
  - If no request is asserted: `out_valid` goes to 0, and `out_data`/`out_ch` hold their values.
- With `ld=0` (`out_valid=1`, `out_ready=0`): all registers hold and `in_ready` is all 0 (backpressure).
- A `mode` change applies to the next arbitration decision. No flush occurs and `ptr` is retained.
- A requester may drop `in_valid` without ever being granted. No state records pending requests.

## Timing
- Reset values (asynchronous, while `rst_n=0`): `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=N-1`. With `ptr=N-1`, the first round-robin search starts at channel 0.
- `in_ready` is combinational from `in_valid`, `mode`, `ptr`, `out_valid` and `out_ready`. There is no combinational path from `in_data`.
- Latency: a word accepted at edge t is visible on `out_*` after edge t, so 1 cycle.
- Throughput: 1 word/cycle while `out_ready=1` and requests are present.
- Simultaneous drain and load: when `out_valid=1`, `out_ready=1` and a request is present, the output is replaced in the same edge with no bubble.
- Round-robin fairness: with all N channels requesting continuously, each channel is granted exactly once in any N consecutive grants.
- Wrap: with `ptr=N-1`, the search begins at 0. With only `ptr`'s own channel requesting, that channel wins again.
- Reset mid-transfer: the held word is discarded, `out_valid` drops immediately (asynchronously), and `ptr` returns to N-1.
- Release: reset deasserts synchronously to `clk` in the surrounding design. The first grant can occur at the first edge after release.

## Test plan
- **Reset.** Assert `rst_n=0` mid-stream with `out_valid=1`. Required: `out_valid=0`, `out_data=0`, `out_ch=0` at once. After release with `mode=1` and all valid, the first `out_ch` is 0.
- **Fixed priority.** N=4, `mode=0`, `in_valid=4'b0110`, `out_ready=1`. Required: `in_ready=4'b0100` and `out_ch=2` next cycle. Then `in_valid=4'b1111` gives `out_ch=3` repeatedly.
- **Round-robin rotation.** `mode=1`, `in_valid=4'b1111`, `out_ready=1` for 8 cycles. Required: `out_ch` sequence 0,1,2,3,0,1,2,3, with each `out_data` equal to the selected slice.
- **Backpressure.** Word from channel 1 held with `out_ready=0` for 3 cycles. Required: `in_ready=0`, and `out_data`/`out_ch` are stable. Raising `out_ready` with channel 2 valid gives `out_ch=2` the next cycle with no bubble.
- **Sparse and idle.** `mode=1`, `ptr=2`, `in_valid=4'b0001`. Required: channel 0 is granted (wrap). Then `in_valid=0` with `out_ready=1` gives `out_valid=0` the next cycle.
- **Mode switch.** After round-robin grants 0 and 1, switch `mode=0` with `in_valid=4'b1011`. Required: channel 3 is granted. Switching back to `mode=1` with `ptr=3` makes channel 0 win.

Source files
------------

// File: rtl/arb_mux_n.sv
// N-channel arbitrating mux: fixed-priority or round-robin winner selection
// feeding a one-entry output register that carries the data word and its channel index.
module arb_mux_n #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_ch,
  input  logic           out_ready
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_win;
  logic          w_any;
  logic          w_ld;

  assign w_ld  = !out_valid || out_ready;
  assign w_any = |in_valid;

  // Round-robin scans offsets N..1 downwards so the smallest offset from
  // ptr+1 is the last assignment and therefore wins.
  always_comb begin
    logic [IW-1:0] v_idx;
    w_win = '0;
    v_idx = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) w_win = IW'(i);
      end
    end else begin
      for (int j = N; j >= 1; j--) begin
        v_idx = IW'((int'(r_ptr) + j) % N);
        if (in_valid[v_idx]) w_win = v_idx;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (w_ld && w_any) in_ready = N'(1) << w_win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      r_ptr     <= IW'(N - 1);
    end else if (w_ld) begin
      if (w_any) begin
        out_valid <= 1'b1;
        out_data  <= in_data[w_win*W +: W];
        out_ch    <= w_win;
        r_ptr     <= w_win;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n (N=4, W=8): an independent arbiter model
// predicts grants and pushes expected words into a scoreboard queue.
module tb_arb_mux_n;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_ready;

  arb_mux_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   m_ptr;
  int   errors = 0;
  int   checks = 0;

  function automatic int model_win(input logic m, input logic [3:0] v, input int p);
    int  w;
    bit  found;
    w = -1;
    found = 0;
    if (!m) begin
      for (int i = N - 1; i >= 0; i--)
        if (!found && v[i]) begin w = i; found = 1; end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (p + 1 + k) % N;
        if (!found && v[c]) begin w = c; found = 1; end
      end
    end
    return w;
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    d = {$urandom, $urandom};
    return d;
  endfunction

  // One clock of stimulus: checks in_ready before the edge, then the output after it.
  task automatic cycle(input string name, input logic m, input logic [3:0] v, input logic ordy);
    logic [N-1:0] exp_rdy;
    int           win;
    bit           ld;
    exp_t         e;
    mode      = m;
    in_valid  = v;
    in_data   = rand_data();
    out_ready = ordy;
    #1;
    win = model_win(m, v, m_ptr);
    ld  = (q.size() == 0) || ordy;
    exp_rdy = (ld && win >= 0) ? (4'b0001 << win) : 4'b0000;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s in_ready: got %b want %b", name, in_ready, exp_rdy);
    end
    @(posedge clk);
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (ld && win >= 0) begin
      e.ch   = win;
      e.data = in_data[win*W +: W];
      q.push_back(e);
      m_ptr = win;
    end
    #1;
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL %s out_valid: got %b want %b", name, out_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if (out_ch !== q[0].ch[1:0] || out_data !== q[0].data) begin
        errors++;
        $display("FAIL %s out_word: got ch=%0d data=%h want ch=%0d data=%h",
                 name, out_ch, out_data, q[0].ch, q[0].data);
      end
    end
  endtask

  task automatic expect_ch(input string name, input int ch);
    checks++;
    if (out_valid !== 1'b1 || int'(out_ch) != ch) begin
      errors++;
      $display("FAIL %s: got valid=%b ch=%0d want valid=1 ch=%0d", name, out_valid, out_ch, ch);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h ch=%0d want 0/00/0", name, out_valid, out_data, out_ch);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    m_ptr = N - 1;
    #1;
  endtask

  task automatic test_reset();
    mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    do_reset();
    check_reset_outputs("reset_initial");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("reset_load", 1'b0, 4'b1000, 1'b0);
    expect_ch("reset_load_ch", 3);
    do_reset();
    check_reset_outputs("reset_midstream");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("reset_first_rr", 1'b1, 4'b1111, 1'b1);
    expect_ch("reset_first_rr_ch", 0);
  endtask

  task automatic test_fixed_priority();
    cycle("fixed_0110", 1'b0, 4'b0110, 1'b1);
    expect_ch("fixed_0110_ch", 2);
    for (int i = 0; i < 3; i++) begin
      cycle("fixed_1111", 1'b0, 4'b1111, 1'b1);
      expect_ch("fixed_1111_ch", 3);
    end
  endtask

  task automatic test_round_robin();
    cycle("rr_align", 1'b0, 4'b1000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle("rr_rotate", 1'b1, 4'b1111, 1'b1);
      expect_ch("rr_rotate_ch", i % N);
    end
  endtask

  task automatic test_backpressure();
    cycle("bp_load", 1'b0, 4'b0010, 1'b1);
    expect_ch("bp_load_ch", 1);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold", 1'b0, 4'b0110, 1'b0);
      expect_ch("bp_hold_ch", 1);
    end
    cycle("bp_release", 1'b0, 4'b0100, 1'b1);
    expect_ch("bp_release_ch", 2);
  endtask

  task automatic test_sparse_idle();
    cycle("sparse_ptr2", 1'b1, 4'b0100, 1'b1);
    cycle("sparse_wrap", 1'b1, 4'b0001, 1'b1);
    expect_ch("sparse_wrap_ch", 0);
    cycle("sparse_idle", 1'b1, 4'b0000, 1'b1);
    cycle("sparse_idle2", 1'b1, 4'b0000, 1'b0);
  endtask

  task automatic test_mode_switch();
    cycle("ms_rr0", 1'b1, 4'b0001, 1'b1);
    cycle("ms_rr1", 1'b1, 4'b0010, 1'b1);
    expect_ch("ms_rr1_ch", 1);
    cycle("ms_fixed", 1'b0, 4'b1011, 1'b1);
    expect_ch("ms_fixed_ch", 3);
    cycle("ms_back_rr", 1'b1, 4'b1111, 1'b1);
    expect_ch("ms_back_rr_ch", 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      cycle("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_backpressure();
    test_sparse_idle();
    test_mode_switch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
